// File: rtl/pwm_duty_decoder_pkg.sv
// rtl/pwm_duty_decoder_pkg.sv - shared state encoding and nominal timing for the PWM duty decoder
// Purpose: decoder FSM state type and default period/timeout values, also used by
//          the PWM generator bench and the line-follower controller.
// Ports:   none (package).
package pwm_duty_decoder_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_EDGE = 2'd0,
        ST_MEASURE   = 2'd1,
        ST_STUCK     = 2'd2
    } dec_state_e;

    localparam int DEF_EXPECTED_PERIOD = 128;
    localparam int DEF_TIMEOUT         = 512;

endpackage

// File: rtl/pwm_duty_decoder_sync_edge_detect.sv
// rtl/pwm_duty_decoder_sync_edge_detect.sv - 2-flop synchroniser with rising-edge detect
// Purpose: brings an asynchronous input into the clock domain and flags its rising edge.
// Ports:   clk_i   - clock
//          rst_ni  - asynchronous active-low reset
//          async_i - asynchronous input line
//          lvl_o   - synchronised level
//          rise_o  - one-cycle rising-edge strobe of lvl_o
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic lvl_o,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign lvl_o  = s2_q;
    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - measures PWM period/high time and recovers the duty code
// Purpose: rise-to-rise period and high-time measurement of a PWM line, duty code
//          recovery, off-nominal period flag and stuck-line detection.
// Ports:   clk_3125KHz - system clock
//          rst_n       - asynchronous active-low reset
//          pwm_in      - asynchronous PWM line
//          meas_valid  - one-cycle pulse, new measurement on the data outputs
//          high_cnt    - high time of last complete period
//          period_cnt  - rise-to-rise length of last complete period
//          duty_code   - high_cnt saturated to DUTY_W bits
//          period_err  - last period differed from EXPECTED_PERIOD
//          stuck       - no rising edge for TIMEOUT cycles
//          stuck_level - line level when stuck was declared
module pwm_duty_decoder
    import pwm_duty_decoder_pkg::*;
#(
    parameter int CNT_W           = 10,
    parameter int DUTY_W          = 4,
    parameter int EXPECTED_PERIOD = DEF_EXPECTED_PERIOD,
    parameter int TIMEOUT         = DEF_TIMEOUT
) (
    input  logic              clk_3125KHz,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic              meas_valid,
    output logic [CNT_W-1:0]  high_cnt,
    output logic [CNT_W-1:0]  period_cnt,
    output logic [DUTY_W-1:0] duty_code,
    output logic              period_err,
    output logic              stuck,
    output logic              stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_C    = CNT_W'(EXPECTED_PERIOD);
    localparam logic [CNT_W-1:0] TO_C     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'((1 << DUTY_W) - 1);

    logic lvl;
    logic rise;

    sync_edge_detect u_sync (
        .clk_i   (clk_3125KHz),
        .rst_ni  (rst_n),
        .async_i (pwm_in),
        .lvl_o   (lvl),
        .rise_o  (rise)
    );

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [DUTY_W-1:0] duty_sat;

    dec_state_e        state_q;
    logic              meas_valid_q;
    logic [CNT_W-1:0]  high_cnt_q;
    logic [CNT_W-1:0]  period_cnt_q;
    logic [DUTY_W-1:0] duty_code_q;
    logic              period_err_q;
    logic              stuck_q;
    logic              stuck_level_q;

    // Both counters restart at 1 on a rise so that the value seen on the
    // next rise equals the full rise-to-rise length including that cycle.
    always_comb begin
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        if (rise) begin
            cnt_d  = CNT_ONE;
            hcnt_d = CNT_ONE;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (lvl && (hcnt_q != CNT_MAX)) begin
                hcnt_d = hcnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        duty_sat = '1;
        if (hcnt_q <= DUTY_MAX) begin
            duty_sat = hcnt_q[DUTY_W-1:0];
        end
    end

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            hcnt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hcnt_q <= hcnt_d;
        end
    end

    // A rise always takes priority over the timeout compare, so a period of
    // exactly TIMEOUT cycles is still measured rather than declared stuck.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_WAIT_EDGE;
            meas_valid_q  <= 1'b0;
            high_cnt_q    <= '0;
            period_cnt_q  <= '0;
            duty_code_q   <= '0;
            period_err_q  <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            case (state_q)
                ST_WAIT_EDGE: begin
                    if (rise) begin
                        state_q <= ST_MEASURE;
                    end else if (cnt_q == TO_C) begin
                        state_q       <= ST_STUCK;
                        stuck_q       <= 1'b1;
                        stuck_level_q <= lvl;
                        duty_code_q   <= lvl ? '1 : '0;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        meas_valid_q <= 1'b1;
                        period_cnt_q <= cnt_q;
                        high_cnt_q   <= hcnt_q;
                        duty_code_q  <= duty_sat;
                        period_err_q <= (cnt_q != EXP_C);
                    end else if (cnt_q == TO_C) begin
                        state_q       <= ST_STUCK;
                        stuck_q       <= 1'b1;
                        stuck_level_q <= lvl;
                        duty_code_q   <= lvl ? '1 : '0;
                    end
                end
                ST_STUCK: begin
                    // First rise after a stuck line only re-arms the measurement.
                    if (rise) begin
                        state_q <= ST_MEASURE;
                        stuck_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_WAIT_EDGE;
                end
            endcase
        end
    end

    assign meas_valid  = meas_valid_q;
    assign high_cnt    = high_cnt_q;
    assign period_cnt  = period_cnt_q;
    assign duty_code   = duty_code_q;
    assign period_err  = period_err_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

endmodule
